// File: rtl/modeline_sequencer_if.sv
// Bundle of the button, direct-select, frame, table-write and modeline signals
// between the board-side controller (master) and modeline_sequencer (slave).
interface modeline_sequencer_if #(
  parameter int MW = 2,
  parameter int TW = 12
);
  logic          but_next;
  logic          but_prev;
  logic          sel_valid;
  logic [MW-1:0] sel_mode;
  logic          frame_end;
  logic          tbl_we;
  logic [MW-1:0] tbl_mode;
  logic [3:0]    tbl_field;
  logic [TW-1:0] tbl_data;

  logic [MW-1:0] mode_idx;
  logic [MW-1:0] clk_sel;
  logic          vid_reset;
  logic          busy;
  logic [TW-1:0] mline_hdisp;
  logic [TW-1:0] mline_hsyncstart;
  logic [TW-1:0] mline_hsyncend;
  logic [TW-1:0] mline_htotal;
  logic          mline_hsyncinvert;
  logic [TW-1:0] mline_vdisp;
  logic [TW-1:0] mline_vsyncstart;
  logic [TW-1:0] mline_vsyncend;
  logic [TW-1:0] mline_vtotal;
  logic          mline_vsyncinvert;

  modport master (
    output but_next, but_prev, sel_valid, sel_mode, frame_end,
           tbl_we, tbl_mode, tbl_field, tbl_data,
    input  mode_idx, clk_sel, vid_reset, busy,
           mline_hdisp, mline_hsyncstart, mline_hsyncend, mline_htotal, mline_hsyncinvert,
           mline_vdisp, mline_vsyncstart, mline_vsyncend, mline_vtotal, mline_vsyncinvert
  );

  modport slave (
    input  but_next, but_prev, sel_valid, sel_mode, frame_end,
           tbl_we, tbl_mode, tbl_field, tbl_data,
    output mode_idx, clk_sel, vid_reset, busy,
           mline_hdisp, mline_hsyncstart, mline_hsyncend, mline_htotal, mline_hsyncinvert,
           mline_vdisp, mline_vsyncstart, mline_vsyncend, mline_vtotal, mline_vsyncinvert
  );
endinterface

// File: rtl/modeline_sequencer.sv
// Glitch-free video mode switcher with a writable modeline table.
// Optional button debounce filter enabled by defining MODESEQ_DEBOUNCE_EN.
module modeline_sequencer #(
  parameter int NUM_MODES       = 4,
  parameter int MW              = 2,
  parameter int TW              = 12,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SETTLE_CYCLES   = 256,
  parameter int FRAME_TIMEOUT   = 4000000
) (
  input logic                 sys_clk,
  input logic                 sys_reset,
  modeline_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam int CNT_MAX = (FRAME_TIMEOUT > SETTLE_CYCLES) ? FRAME_TIMEOUT : SETTLE_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [MW:0]   NUM_M     = (MW + 1)'(NUM_MODES);
  localparam logic [MW-1:0] LAST_MODE = MW'(NUM_MODES - 1);

  // Timing slots 0..3 are horizontal, 4..7 vertical; reset table is 720p.
  function automatic logic [TW-1:0] reset_field(input int unsigned slot);
    case (slot)
      32'd0:   reset_field = TW'(1280);
      32'd1:   reset_field = TW'(1390);
      32'd2:   reset_field = TW'(1430);
      32'd3:   reset_field = TW'(1650);
      32'd4:   reset_field = TW'(720);
      32'd5:   reset_field = TW'(725);
      32'd6:   reset_field = TW'(730);
      32'd7:   reset_field = TW'(750);
      default: reset_field = {TW{1'b0}};
    endcase
  endfunction

  logic [TW-1:0] tbl_q [NUM_MODES][8];
  logic [1:0]    inv_q [NUM_MODES];
  logic          wr_ok_s, wr_inv_s, wr_inv_sel_s;
  logic [2:0]    wr_slot_s;

  state_e        state_q, state_d;
  logic [MW-1:0] tgt_q, tgt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_s;

  logic [1:0]    sync1_q, sync2_q, lvl_prev_q, req_btn_q, lvl_s;
  logic          req_s;
  logic [MW-1:0] req_tgt_s;

  logic [MW-1:0] mode_q;
  logic [TW-1:0] mline_q [8];
  logic [1:0]    minv_q;
  logic          busy_q, vres_q;

  // Decode a table write into a timing slot or an invert bit.
  always_comb begin
    wr_ok_s      = 1'b0;
    wr_inv_s     = 1'b0;
    wr_inv_sel_s = 1'b0;
    wr_slot_s    = 3'd0;
    if (bus.tbl_we && ({1'b0, bus.tbl_mode} < NUM_M)) begin
      case (bus.tbl_field)
        4'd0, 4'd1, 4'd2, 4'd3: begin wr_ok_s = 1'b1; wr_slot_s = bus.tbl_field[2:0]; end
        4'd5, 4'd6, 4'd7, 4'd8: begin wr_ok_s = 1'b1; wr_slot_s = 3'(bus.tbl_field - 4'd1); end
        4'd4:    begin wr_inv_s = 1'b1; wr_inv_sel_s = 1'b0; end
        4'd9:    begin wr_inv_s = 1'b1; wr_inv_sel_s = 1'b1; end
        default: wr_ok_s = 1'b0;
      endcase
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Modeline table storage.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      for (int m = 0; m < NUM_MODES; m++) begin
        for (int s = 0; s < 8; s++) tbl_q[m][s] <= reset_field(s);
        inv_q[m] <= 2'b00;
      end
    end else if (wr_ok_s) begin
      tbl_q[bus.tbl_mode][wr_slot_s] <= bus.tbl_data;
    end else if (wr_inv_s) begin
      inv_q[bus.tbl_mode][wr_inv_sel_s] <= bus.tbl_data[0];
    end
  end

  // Button synchroniser and rising-edge detector; bit 0 next, bit 1 prev.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      lvl_prev_q <= 2'b00;
      req_btn_q  <= 2'b00;
    end else begin
      sync1_q    <= {bus.but_prev, bus.but_next};
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl_s;
      req_btn_q  <= lvl_s & ~lvl_prev_q;
    end
  end

`ifdef MODESEQ_DEBOUNCE_EN
  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]     deb_lvl_q;
  logic [DCW-1:0] deb_cnt_q [2];

  // A level is accepted only after differing from the filtered level for DEBOUNCE_CYCLES.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      deb_lvl_q <= 2'b00;
      for (int b = 0; b < 2; b++) deb_cnt_q[b] <= {DCW{1'b0}};
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync2_q[b] == deb_lvl_q[b]) begin
          deb_cnt_q[b] <= {DCW{1'b0}};
        end else if (deb_cnt_q[b] == DCW'(DEBOUNCE_CYCLES - 1)) begin
          deb_lvl_q[b] <= sync2_q[b];
          deb_cnt_q[b] <= {DCW{1'b0}};
        end else begin
          deb_cnt_q[b] <= deb_cnt_q[b] + DCW'(1);
        end
      end
    end
  end

  assign lvl_s = deb_lvl_q;
`else
  assign lvl_s = sync2_q;
`endif

  // Request arbitration: valid direct select, then next, then prev.
  always_comb begin
    req_s     = 1'b0;
    req_tgt_s = mode_q;
    if (bus.sel_valid && ({1'b0, bus.sel_mode} < NUM_M) && (bus.sel_mode != mode_q)) begin
      req_s     = 1'b1;
      req_tgt_s = bus.sel_mode;
    end else if ((NUM_MODES > 1) && req_btn_q[0]) begin
      req_s     = 1'b1;
      req_tgt_s = (mode_q == LAST_MODE) ? {MW{1'b0}} : mode_q + MW'(1);
    end else if ((NUM_MODES > 1) && req_btn_q[1]) begin
      req_s     = 1'b1;
      req_tgt_s = (mode_q == {MW{1'b0}}) ? LAST_MODE : mode_q - MW'(1);
    end else begin
      req_s = 1'b0;
    end
  end

  // Switch sequencing next-state logic.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = {CW{1'b0}};
        if (req_s) begin
          tgt_d   = req_tgt_s;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.frame_end || (cnt_q == CW'(FRAME_TIMEOUT - 1))) begin
          state_d = S_HOLD;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d = S_IDLE;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  assign load_s = (state_q == S_WAIT) && (state_d == S_HOLD);

  // Sequencer state register; reset parks in HOLD targeting mode 0.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q <= S_HOLD;
      tgt_q   <= {MW{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs; the modeline and clock select only move on HOLD entry.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      mode_q <= {MW{1'b0}};
      for (int k = 0; k < 8; k++) mline_q[k] <= reset_field(k);
      minv_q <= 2'b00;
      busy_q <= 1'b1;
      vres_q <= 1'b1;
    end else begin
      busy_q <= (state_d != S_IDLE);
      vres_q <= (state_d == S_HOLD);
      if (load_s) begin
        mode_q <= tgt_q;
        for (int k = 0; k < 8; k++) mline_q[k] <= tbl_q[tgt_q][k];
        minv_q <= inv_q[tgt_q];
      end
    end
  end

  assign bus.mode_idx          = mode_q;
  assign bus.clk_sel           = mode_q;
  assign bus.busy              = busy_q;
  assign bus.vid_reset         = vres_q;
  assign bus.mline_hdisp       = mline_q[0];
  assign bus.mline_hsyncstart  = mline_q[1];
  assign bus.mline_hsyncend    = mline_q[2];
  assign bus.mline_htotal      = mline_q[3];
  assign bus.mline_vdisp       = mline_q[4];
  assign bus.mline_vsyncstart  = mline_q[5];
  assign bus.mline_vsyncend    = mline_q[6];
  assign bus.mline_vtotal      = mline_q[7];
  assign bus.mline_hsyncinvert = minv_q[0];
  assign bus.mline_vsyncinvert = minv_q[1];

endmodule

// File: tb/tb_modeline_sequencer.sv
// Self-checking bench for modeline_sequencer: scoreboard of expected modes
// checked at every HOLD entry, plus per-scenario inline checks.
module tb_modeline_sequencer;

  localparam int NM = 4;
  localparam int SETTLE = 8;
  localparam int FTO = 100;
`ifdef MODESEQ_DEBOUNCE_EN
  localparam int BTN_LAT = 20;
`else
  localparam int BTN_LAT = 4;
`endif

  logic clk = 1'b0;
  logic sys_reset;
  int   n_total = 0;
  int   n_pass = 0;
  int   tbl_m [NM][10];
  int   mode_m;
  int   exp_q [$];
  bit   vr_prev = 1'b1;

  modeline_sequencer_if #(.MW(2), .TW(12)) bus ();

  modeline_sequencer #(
    .NUM_MODES(NM), .MW(2), .TW(12), .DEBOUNCE_CYCLES(16),
    .SETTLE_CYCLES(SETTLE), .FRAME_TIMEOUT(FTO)
  ) dut (
    .sys_clk(clk),
    .sys_reset(sys_reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int dut_field(int k);
    case (k)
      0: return int'(bus.mline_hdisp);
      1: return int'(bus.mline_hsyncstart);
      2: return int'(bus.mline_hsyncend);
      3: return int'(bus.mline_htotal);
      4: return int'(bus.mline_hsyncinvert);
      5: return int'(bus.mline_vdisp);
      6: return int'(bus.mline_vsyncstart);
      7: return int'(bus.mline_vsyncend);
      8: return int'(bus.mline_vtotal);
      9: return int'(bus.mline_vsyncinvert);
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    int rv [10] = '{1280, 1390, 1430, 1650, 0, 720, 725, 730, 750, 0};
    for (int m = 0; m < NM; m++)
      for (int f = 0; f < 10; f++) tbl_m[m][f] = rv[f];
    mode_m = 0;
  endtask

  // Scoreboard: every rising vid_reset outside reset is one applied switch.
  always @(negedge clk) begin
    if (sys_reset === 1'b1) begin
      vr_prev = 1'b1;
    end else begin
      if (bus.vid_reset === 1'b1 && !vr_prev) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_switch: got mode %0d, required no switch", bus.mode_idx);
        end else begin
          int m;
          int bad;
          m = exp_q.pop_front();
          bad = 0;
          for (int f = 0; f < 10; f++) if (dut_field(f) !== tbl_m[m][f]) bad++;
          if (bus.mode_idx !== 2'(m) || bus.clk_sel !== 2'(m) || bad != 0)
            $display("FAIL sb_switch: got mode %0d clk_sel %0d htotal %0d vtotal %0d (%0d bad fields), required mode %0d htotal %0d vtotal %0d",
                     bus.mode_idx, bus.clk_sel, bus.mline_htotal, bus.mline_vtotal, bad, m, tbl_m[m][3], tbl_m[m][8]);
          else n_pass++;
          mode_m = m;
        end
      end
      vr_prev = bus.vid_reset;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tbl_write(int m, int f, int d);
    bus.tbl_we = 1'b1; bus.tbl_mode = 2'(m); bus.tbl_field = 4'(f); bus.tbl_data = 12'(d);
    tick(1);
    bus.tbl_we = 1'b0;
    if (m < NM && f <= 9) tbl_m[m][f] = (f == 4 || f == 9) ? (d & 1) : d;
  endtask

  task automatic wait_busy(output int lat);
    lat = 0;
    while (bus.busy !== 1'b1 && lat < 60) begin tick(1); lat++; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 400) begin tick(1); n++; end
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL idle_timeout: busy %b after %0d cycles, required 0", bus.busy, n);
    else n_pass++;
  endtask

  task automatic pulse_frame_end();
    bus.frame_end = 1'b1; tick(1); bus.frame_end = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    sys_reset = 1'b1;
    model_reset();
    tick(3);
    n_total++;
    if (bus.mode_idx !== 2'd0 || bus.mline_htotal !== 12'd1650 || bus.mline_vtotal !== 12'd750 ||
        bus.busy !== 1'b1 || bus.vid_reset !== 1'b1)
      $display("FAIL reset_state: mode %0d htotal %0d vtotal %0d busy %b vid_reset %b, required 0 1650 750 1 1",
               bus.mode_idx, bus.mline_htotal, bus.mline_vtotal, bus.busy, bus.vid_reset);
    else n_pass++;
    sys_reset = 1'b0;
    cnt = 0;
    while (bus.vid_reset === 1'b1 && cnt < 50) begin
      n_total++;
      if (bus.busy !== 1'b1) $display("FAIL reset_busy_high: busy %b in settle cycle %0d, required 1", bus.busy, cnt);
      else n_pass++;
      cnt++; tick(1);
    end
    n_total++;
    if (cnt != SETTLE) $display("FAIL reset_settle_len: got %0d cycles, required %0d", cnt, SETTLE);
    else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy_fall: busy %b, required 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_next_switch();
    int lat, cnt;
    tbl_write(1, 3, 1688);
    tbl_write(1, 8, 1066);
    exp_q.push_back(1);
    bus.but_next = 1'b1;
    wait_busy(lat);
    n_total++;
    if (lat != BTN_LAT) $display("FAIL next_latency: got %0d cycles to busy, required %0d", lat, BTN_LAT);
    else n_pass++;
    tick(2);
    n_total++;
    if (bus.mode_idx !== 2'd0 || bus.vid_reset !== 1'b0)
      $display("FAIL next_wait_hold: mode %0d vid_reset %b, required 0 0", bus.mode_idx, bus.vid_reset);
    else n_pass++;
    pulse_frame_end();
    n_total++;
    if (bus.vid_reset !== 1'b1 || bus.mode_idx !== 2'd1 || bus.clk_sel !== 2'd1 ||
        bus.mline_htotal !== 12'd1688 || bus.mline_vtotal !== 12'd1066)
      $display("FAIL next_apply: vid_reset %b mode %0d clk_sel %0d htotal %0d vtotal %0d, required 1 1 1 1688 1066",
               bus.vid_reset, bus.mode_idx, bus.clk_sel, bus.mline_htotal, bus.mline_vtotal);
    else n_pass++;
    cnt = 0;
    while (bus.vid_reset === 1'b1 && cnt < 50) begin cnt++; tick(1); end
    n_total++;
    if (cnt != SETTLE || bus.busy !== 1'b0)
      $display("FAIL next_settle: vid_reset high %0d cycles busy %b, required %0d and 0", cnt, bus.busy, SETTLE);
    else n_pass++;
    bus.but_next = 1'b0;
    tick(30);
  endtask

  task automatic switch_button(bit nxt);
    int m, lat;
    m = nxt ? (mode_m + 1) % NM : (mode_m + NM - 1) % NM;
    exp_q.push_back(m);
    if (nxt) bus.but_next = 1'b1; else bus.but_prev = 1'b1;
    wait_busy(lat);
    tick(1);
    pulse_frame_end();
    wait_idle();
    bus.but_next = 1'b0; bus.but_prev = 1'b0;
    n_total++;
    if (bus.mode_idx !== 2'(m)) $display("FAIL button_%s: got mode %0d, required %0d", nxt ? "next" : "prev", bus.mode_idx, m);
    else n_pass++;
    tick(30);
  endtask

  task automatic test_wrap();
    switch_button(1'b0);
    switch_button(1'b0);
    switch_button(1'b1);
  endtask

  task automatic sel_switch(int m);
    exp_q.push_back(m);
    bus.sel_valid = 1'b1; bus.sel_mode = 2'(m);
    tick(1);
    bus.sel_valid = 1'b0;
    pulse_frame_end();
    wait_idle();
    n_total++;
    if (bus.mode_idx !== 2'(m)) $display("FAIL sel_switch: got mode %0d, required %0d", bus.mode_idx, m);
    else n_pass++;
  endtask

  task automatic test_priority();
    exp_q.push_back(2);
    bus.but_next = 1'b1;
    tick(BTN_LAT - 1);
    bus.sel_valid = 1'b1; bus.sel_mode = 2'd2;
    tick(1);
    bus.sel_valid = 1'b0;
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL prio_busy: busy %b, required 1", bus.busy);
    else n_pass++;
    tick(1);
    bus.sel_valid = 1'b1; bus.sel_mode = 2'd1;
    tick(1);
    bus.sel_valid = 1'b0;
    pulse_frame_end();
    wait_idle();
    n_total++;
    if (bus.mode_idx !== 2'd2) $display("FAIL prio_mode: got mode %0d, required 2", bus.mode_idx);
    else n_pass++;
    bus.but_next = 1'b0;
    tick(30);
    bus.sel_valid = 1'b1; bus.sel_mode = 2'd2;
    tick(1);
    bus.sel_valid = 1'b0;
    tick(3);
    n_total++;
    if (bus.busy !== 1'b0 || bus.mode_idx !== 2'd2)
      $display("FAIL sel_same_mode: busy %b mode %0d, required 0 2", bus.busy, bus.mode_idx);
    else n_pass++;
  endtask

  task automatic test_timeout_reset();
    int n;
    exp_q.push_back(1);
    bus.sel_valid = 1'b1; bus.sel_mode = 2'd1;
    tick(1);
    bus.sel_valid = 1'b0;
    n_total++;
    if (bus.busy !== 1'b1 || bus.vid_reset !== 1'b0)
      $display("FAIL timeout_wait_entry: busy %b vid_reset %b, required 1 0", bus.busy, bus.vid_reset);
    else n_pass++;
    n = 0;
    while (bus.vid_reset !== 1'b1 && n < 300) begin tick(1); n++; end
    n_total++;
    if (n != FTO) $display("FAIL timeout_len: HOLD after %0d cycles, required %0d", n, FTO);
    else n_pass++;
    tick(3);
    sys_reset = 1'b1;
    model_reset();
    tick(2);
    n_total++;
    if (bus.mode_idx !== 2'd0 || bus.clk_sel !== 2'd0 || bus.mline_htotal !== 12'd1650 ||
        bus.busy !== 1'b1 || bus.vid_reset !== 1'b1)
      $display("FAIL midhold_reset: mode %0d clk_sel %0d htotal %0d busy %b vid_reset %b, required 0 0 1650 1 1",
               bus.mode_idx, bus.clk_sel, bus.mline_htotal, bus.busy, bus.vid_reset);
    else n_pass++;
    sys_reset = 1'b0;
    wait_idle();
    n_total++;
    if (bus.mode_idx !== 2'd0) $display("FAIL midhold_release: mode %0d, required 0", bus.mode_idx);
    else n_pass++;
  endtask

  task automatic test_table_isolation();
    tbl_write(0, 0, 1920);
    tbl_write(2, 4, 1);
    tbl_write(2, 5, 600);
    tbl_write(2, 10, 5);
    tbl_write(0, 15, 9);
    tick(2);
    n_total++;
    if (bus.mline_hdisp !== 12'd1280) $display("FAIL active_write_isolated: hdisp %0d, required 1280", bus.mline_hdisp);
    else n_pass++;
    sel_switch(2);
    n_total++;
    if (bus.mline_hsyncinvert !== 1'b1 || bus.mline_vdisp !== 12'd600 || bus.mline_vsyncinvert !== 1'b0)
      $display("FAIL table_entry2: hinv %b vdisp %0d vinv %b, required 1 600 0",
               bus.mline_hsyncinvert, bus.mline_vdisp, bus.mline_vsyncinvert);
    else n_pass++;
    sel_switch(0);
    n_total++;
    if (bus.mline_hdisp !== 12'd1920) $display("FAIL table_reapply: hdisp %0d, required 1920", bus.mline_hdisp);
    else n_pass++;
  endtask

`ifdef MODESEQ_DEBOUNCE_EN
  task automatic test_debounce();
    bit seen;
    int lat;
    seen = 1'b0;
    bus.but_next = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (i == 9) bus.but_next = 1'b0;
      if (bus.busy === 1'b1) seen = 1'b1;
    end
    n_total++;
    if (seen) $display("FAIL debounce_glitch: busy seen 1, required 0");
    else n_pass++;
    exp_q.push_back((mode_m + 1) % NM);
    lat = 0;
    bus.but_next = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (i == 20) bus.but_next = 1'b0;
      if (bus.busy === 1'b1 && lat == 0) lat = i;
    end
    n_total++;
    if (lat != BTN_LAT) $display("FAIL debounce_latency: got %0d, required %0d", lat, BTN_LAT);
    else n_pass++;
    pulse_frame_end();
    wait_idle();
    tick(40);
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL debounce_single: busy %b, required 0", bus.busy);
    else n_pass++;
  endtask
`endif

  initial begin
    bus.but_next = 1'b0; bus.but_prev = 1'b0; bus.sel_valid = 1'b0; bus.sel_mode = 2'd0;
    bus.frame_end = 1'b0; bus.tbl_we = 1'b0; bus.tbl_mode = 2'd0; bus.tbl_field = 4'd0;
    bus.tbl_data = 12'd0; sys_reset = 1'b1;
    test_reset();
    test_next_switch();
    test_wrap();
    test_priority();
    test_timeout_reset();
    test_table_isolation();
`ifdef MODESEQ_DEBOUNCE_EN
    test_debounce();
`endif
    tick(2);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: %0d expected switches not seen, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/modeline_sequencer.md
# modeline_sequencer

Parametrised video-mode controller between the board buttons and `vidcon`. It holds a writable table of NUM_MODES modelines, takes mode changes from next/prev buttons or a direct-select port, and applies them glitch-free. Each change waits for a frame boundary, holds the video pipeline in reset, switches the pixel-clock select and modeline registers together, then releases. It replaces the ad-hoc button-clocked mode counter and latch with a single-clock, synchronous design.

## Interface
Parameters:
- NUM_MODES, 4: number of modeline table entries (1..16).
- MW, 2: mode index / clock-select width; NUM_MODES ≤ 2^MW.
- TW, 12: timing field width.
- DEBOUNCE_CYCLES, 1000000: stable-input cycles to accept a button level (debounce build only).
- SETTLE_CYCLES, 256: cycles `vid_reset` is held per switch (≥ 2).
- FRAME_TIMEOUT, 4000000: max cycles to wait for `frame_end` before switching anyway.

Ports:
- sys_clk  in  1  sole clock.
- sys_reset  in  1  synchronous, active-high reset.
- but_next  in  1  raw asynchronous button, advance mode.
- but_prev  in  1  raw asynchronous button, retreat mode.
- sel_valid  in  1  one-cycle direct-select strobe.
- sel_mode  in  MW  direct-select target.
- frame_end  in  1  one-cycle pulse from `vidcon` at end of last active line, sys_clk domain.
- tbl_we  in  1  table write strobe.
- tbl_mode  in  MW  table entry to write.
- tbl_field  in  4  field: 0 hdisp, 1 hsyncstart, 2 hsyncend, 3 htotal, 4 hsyncinvert, 5 vdisp, 6 vsyncstart, 7 vsyncend, 8 vtotal, 9 vsyncinvert.
- tbl_data  in  TW  write data; invert fields use bit 0.
- mode_idx  out  MW  active mode.
- clk_sel  out  MW  pixel-clock mux select, equal to mode_idx.
- vid_reset  out  1  reset to `vidcon`, active-high.
- busy  out  1  switch in progress; new requests ignored.
- mline_hdisp, mline_hsyncstart, mline_hsyncend, mline_htotal, mline_vdisp, mline_vsyncstart, mline_vsyncend, mline_vtotal  out  TW each  active modeline.
- mline_hsyncinvert, mline_vsyncinvert  out  1 each.

## Operation
- Table reset contents: every entry is 1280/1390/1430/1650/0 and 720/725/730/750/0 (720p).
- Table writes are accepted in any state.
- Writes with `tbl_mode` ≥ NUM_MODES or `tbl_field` > 9 are dropped.
- Writes to the active entry do not affect the `mline_*` outputs until that mode is next applied.
- Buttons pass through a 2-FF synchroniser, then a rising-edge detector, giving one request per press.
- Request priority within one cycle: sel_valid > next > prev.
- Next wraps from NUM_MODES-1 to 0. Prev wraps from 0 to NUM_MODES-1. Both are ignored when NUM_MODES = 1.
- A sel_valid request is dropped if `sel_mode` ≥ NUM_MODES or `sel_mode` equals the active mode.
- States:
  - IDLE: busy=0. An accepted request latches the target and moves to WAIT_FRAME.
  - WAIT_FRAME: busy=1. Moves to HOLD on `frame_end`, or after FRAME_TIMEOUT cycles.
  - HOLD: vid_reset=1. On entry, mode_idx, clk_sel and all `mline_*` load from the target entry in the same cycle. Counts SETTLE_CYCLES, then moves to IDLE.
- Requests arriving outside IDLE are discarded, not queued.

## Timing
- During reset and on release: state HOLD with target 0, so mode_idx=0, clk_sel=0, `mline_*` = entry 0 reset values, busy=1, vid_reset=1.
- After reset releases, vid_reset stays high for SETTLE_CYCLES cycles, then busy and vid_reset fall in the same cycle.
- Button latency: a raw edge produces a request 3 cycles later in non-debounce builds.
- Request to WAIT_FRAME: 1 cycle.
- `frame_end` high in cycle N: HOLD in N+1, with new outputs and vid_reset=1 in N+1.
- vid_reset is high for exactly SETTLE_CYCLES cycles.
- A `frame_end` coinciding with the timeout is treated as a single event.
- sys_reset asserted mid-switch returns to the reset state above, and the pending target is lost.
- Outputs are registered and change only on HOLD entry or reset.

## Configuration
- MODESEQ_DEBOUNCE_EN defined:
  - After synchronisation, each button level must be stable for DEBOUNCE_CYCLES before the edge detector sees it.
  - Press latency becomes DEBOUNCE_CYCLES+3 cycles.
- MODESEQ_DEBOUNCE_EN undefined: synchroniser and edge detector only; DEBOUNCE_CYCLES is unused.

## Test plan
- Reset with NUM_MODES=4, SETTLE_CYCLES=8: mode_idx=0, mline_htotal=1650, mline_vtotal=750; vid_reset high for 8 cycles after release, busy falls with it.
- Write entry 1 htotal=1688, vtotal=1066; press next; pulse frame_end: the next cycle mode_idx=1, clk_sel=1, mline_htotal=1688, mline_vtotal=1066, vid_reset=1 for 8 cycles.
- From mode 0 press prev: mode becomes 3. From mode 3 press next: mode becomes 0.
- In one IDLE cycle assert sel_valid (sel_mode=2) and next: mode 2 is applied. A second sel_valid during busy is ignored. sel_mode=2 while at mode 2 leaves busy low.
- Request without frame_end, FRAME_TIMEOUT=100: HOLD is entered exactly 100 cycles after WAIT_FRAME entry. sys_reset asserted mid-HOLD returns mode_idx to 0.
- MODESEQ_DEBOUNCE_EN, DEBOUNCE_CYCLES=16: 10-cycle glitches on but_next cause no request; a 20-cycle press gives exactly one request, 19 cycles after the edge.
